// File: rtl/merge_fill_scheduler_if.sv
// Handshake/bus bundle between the merge fill scheduler and its neighbours
// (frame timing, VGA reader, bg/sprite sources, merge datapath).
interface merge_fill_scheduler_if;
  logic        frame_start;
  logic        chunk_done;
  logic [9:0]  fetch_x;
  logic [9:0]  fetch_y;
  logic        fetch_valid;
  logic        pix_valid;
  logic        pix_bank;
  logic [1:0]  bank_full;
  logic        rd_bank;
  logic        busy;
  logic        frame_done;
  logic        underrun;
  logic [15:0] stall_cycles;

  modport slave (
    input  frame_start, chunk_done,
    output fetch_x, fetch_y, fetch_valid, pix_valid, pix_bank,
           bank_full, rd_bank, busy, frame_done, underrun, stall_cycles
  );

  modport master (
    output frame_start, chunk_done,
    input  fetch_x, fetch_y, fetch_valid, pix_valid, pix_bank,
           bank_full, rd_bank, busy, frame_done, underrun, stall_cycles
  );
endinterface

// File: rtl/merge_fill_scheduler.sv
// Ping-pong line-buffer fill scheduler: issues raster fetches, tags banks, tracks full/empty.
// Optional WAIT-cycle statistics counter enabled by defining MERGE_FILL_STATS_EN.
module merge_fill_scheduler #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int CHUNK     = 16,
  parameter int FETCH_LAT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  merge_fill_scheduler_if.slave   sched
);

  localparam int              CW       = $clog2(CHUNK);
  localparam logic [9:0]      X_LAST   = 10'(H_ACTIVE - 1);
  localparam logic [9:0]      Y_LAST   = 10'(V_ACTIVE - 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(CHUNK - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam int              LS       = FETCH_LAT - 1;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_WAIT, ST_DRAIN} state_e;

  state_e          state_q;
  logic [9:0]      x_q, y_q;
  logic [CW-1:0]   cnt_q;
  logic            fetch_valid_q;
  logic            wr_bank_q;

  // Delay line: valid, bank, chunk-last and frame-last tags per stage.
  logic [FETCH_LAT-1:0] pv_q, pb_q, pl_q, pe_q;

  logic [1:0]      bank_full_q, bank_full_d;
  logic            rd_bank_q;
  logic            underrun_q;

  logic            issue, chunk_end, frame_end;
  logic [1:0]      inflight, bank_free;
  logic            set_en, set_bank, release_ok;

  assign issue     = (state_q == ST_FILL);
  assign chunk_end = (cnt_q == CNT_LAST);
  assign frame_end = (x_q == X_LAST) && (y_q == Y_LAST);

  // A bank is only reusable once its full bit is clear and nothing still in flight targets it.
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    inflight = '0;
    for (int i = 0; i < FETCH_LAT; i++) begin
      if (pv_q[i]) inflight[pb_q[i]] = 1'b1;
    end
  end

  assign bank_free = ~bank_full_q & ~inflight;

  assign set_en     = pv_q[LS] & pl_q[LS];
  assign set_bank   = pb_q[LS];
  // A release colliding with a set on the same bank loses: the freshly filled data stays.
  assign release_ok = sched.chunk_done & bank_full_q[rd_bank_q]
                    & ~(set_en & (set_bank == rd_bank_q));

  always_comb begin
    bank_full_d = bank_full_q;
    if (release_ok) bank_full_d[rd_bank_q] = 1'b0;
    if (set_en)     bank_full_d[set_bank]  = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state_q       <= ST_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      cnt_q         <= '0;
      fetch_valid_q <= 1'b0;
      wr_bank_q     <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sched.frame_start) begin
            state_q       <= ST_FILL;
            fetch_valid_q <= 1'b1;
            x_q           <= '0;
            y_q           <= '0;
            cnt_q         <= '0;
          end
        end
        ST_FILL: begin
          cnt_q <= chunk_end ? '0 : cnt_q + CNT_ONE;
          if (chunk_end) wr_bank_q <= ~wr_bank_q;
          if (frame_end) begin
            x_q           <= '0;
            y_q           <= '0;
            state_q       <= ST_DRAIN;
            fetch_valid_q <= 1'b0;
          end else begin
            if (x_q == X_LAST) begin
              x_q <= '0;
              y_q <= y_q + 10'd1;
            end else begin
              x_q <= x_q + 10'd1;
            end
            if (chunk_end && !bank_free[~wr_bank_q]) begin
              state_q       <= ST_WAIT;
              fetch_valid_q <= 1'b0;
            end
          end
        end
        ST_WAIT: begin
          if (bank_free[wr_bank_q]) begin
            state_q       <= ST_FILL;
            fetch_valid_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (pv_q == '0) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: the delay line is control state, so it is reset; stale valids would fake bank fills.
    if (!reset) begin
      pv_q <= '0;
      pb_q <= '0;
      pl_q <= '0;
      pe_q <= '0;
    end else begin
      pv_q[0] <= issue;
      pb_q[0] <= issue & wr_bank_q;
      pl_q[0] <= issue & chunk_end;
      pe_q[0] <= issue & frame_end;
      for (int i = 1; i < FETCH_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pb_q[i] <= pb_q[i-1];
        pl_q[i] <= pl_q[i-1];
        pe_q[i] <= pe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_full_q <= '0;
      rd_bank_q   <= 1'b1;
      underrun_q  <= 1'b0;
    end else begin
      bank_full_q <= bank_full_d;
      if (release_ok) rd_bank_q <= ~rd_bank_q;
      if (sched.chunk_done && !release_ok) underrun_q <= 1'b1;
    end
  end

`ifdef MERGE_FILL_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (state_q == ST_IDLE && sched.frame_start) begin
      stall_q <= '0;
    end else if (state_q == ST_WAIT && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign sched.stall_cycles = stall_q;
`else
  assign sched.stall_cycles = '0;
`endif

  assign sched.fetch_x     = x_q;
  assign sched.fetch_y     = y_q;
  assign sched.fetch_valid = fetch_valid_q;
  assign sched.pix_valid   = pv_q[LS];
  assign sched.pix_bank    = pb_q[LS];
  assign sched.frame_done  = pv_q[LS] & pe_q[LS];
  assign sched.bank_full   = bank_full_q;
  assign sched.rd_bank     = rd_bank_q;
  assign sched.busy        = (state_q != ST_IDLE);
  assign sched.underrun    = underrun_q;

endmodule

// File: tb/tb_merge_fill_scheduler.sv
// Self-checking bench: scoreboard on the main instance plus a FETCH_LAT=3 instance
// for the same-bank set/release collision.
module tb_merge_fill_scheduler;

  localparam int H    = 640;
  localparam int V    = 6;
  localparam int CH   = 16;
  localparam int LAT  = 1;
  localparam int H3   = 64;
  localparam int V3   = 2;
  localparam int LAT3 = 3;
  localparam int N_CHUNKS = H * V / CH;
  localparam logic [9:0] TX_LAST = 10'(H - 1);
  localparam logic [9:0] TY_LAST = 10'(V - 1);

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  merge_fill_scheduler_if bus  ();
  merge_fill_scheduler_if bus3 ();

  merge_fill_scheduler #(.H_ACTIVE(H), .V_ACTIVE(V), .CHUNK(CH), .FETCH_LAT(LAT)) u_dut (
    .clk   (clk),
    .reset (reset),
    .sched (bus.slave)
  );

  merge_fill_scheduler #(.H_ACTIVE(H3), .V_ACTIVE(V3), .CHUNK(CH), .FETCH_LAT(LAT3)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .sched (bus3.slave)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard for u_dut: expected tags pushed at issue, popped at pix_valid.
  typedef struct packed {
    logic        bank;
    logic        final_px;
    logic [31:0] cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [9:0] m_x = '0;
  logic [9:0] m_y = '0;
  int         m_cnt = 0;
  logic       m_bank = 1'b1;
  logic       m_active = 1'b0;
  int         cyc = 0;
  int         pix_cnt = 0;
  int         done_cnt = 0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!reset) begin
      exp_q.delete();
      m_active = 1'b0;
      m_bank   = 1'b1;
      m_cnt    = 0;
    end else begin
      if (bus.fetch_valid) begin
        checks++;
        if (!m_active || bus.fetch_x !== m_x || bus.fetch_y !== m_y) begin
          errors++;
          $display("FAIL issue_coord: got (%0d,%0d) active=%0b, want (%0d,%0d)",
                   bus.fetch_x, bus.fetch_y, m_active, m_x, m_y);
        end
        e.bank     = m_bank;
        e.final_px = (m_x == TX_LAST) && (m_y == TY_LAST);
        e.cyc      = cyc;
        exp_q.push_back(e);
        if (e.final_px) begin
          m_x = '0;
          m_y = '0;
        end else if (m_x == TX_LAST) begin
          m_x = '0;
          m_y = m_y + 10'd1;
        end else begin
          m_x = m_x + 10'd1;
        end
        m_cnt++;
        if (m_cnt == CH) begin
          m_cnt  = 0;
          m_bank = ~m_bank;
        end
      end
      if (bus.pix_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pix_unexpected: pix_valid=1 with nothing issued");
        end else begin
          e = exp_q.pop_front();
          pix_cnt++;
          if (bus.pix_bank !== e.bank || bus.frame_done !== e.final_px ||
              (cyc - int'(e.cyc)) != LAT) begin
            errors++;
            $display("FAIL pix_tag: got bank=%0b done=%0b lag=%0d, want bank=%0b done=%0b lag=%0d",
                     bus.pix_bank, bus.frame_done, cyc - int'(e.cyc), e.bank, e.final_px, LAT);
          end
          if (e.final_px) m_active = 1'b0;
        end
      end else begin
        checks++;
        if (bus.frame_done !== 1'b0) begin
          errors++;
          $display("FAIL frame_done_stray: got 1 without pix_valid, want 0");
        end
      end
      if (bus.frame_done === 1'b1) done_cnt++;
      if (bus.frame_start && !m_active) begin
        m_active = 1'b1;
        m_x      = '0;
        m_y      = '0;
        m_cnt    = 0;
        pix_cnt  = 0;
        done_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [43:0] snap;
    reset = 1'b0;
    bus.frame_start  = 1'b0;
    bus.chunk_done   = 1'b0;
    bus3.frame_start = 1'b0;
    bus3.chunk_done  = 1'b0;
    repeat (3) tick();
    snap = {bus.fetch_x, bus.fetch_y, bus.fetch_valid, bus.pix_valid, bus.pix_bank,
            bus.bank_full, bus.busy, bus.frame_done, bus.underrun, bus.stall_cycles};
    checks++;
    if (snap !== '0 || bus.rd_bank !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got outputs=%h rd_bank=%0b, want 0 and 1", snap, bus.rd_bank);
    end
    reset = 1'b1;
    repeat (2) tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%0b fetch_valid=%0b, want 0 0",
               bus.busy, bus.fetch_valid);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [43:0] snap;
    int          seen;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    repeat (5) tick();
    checks++;
    if (bus.fetch_valid !== 1'b1 || bus.fetch_x !== 10'd5) begin
      errors++;
      $display("FAIL mid_fill_pos: got valid=%0b x=%0d, want 1 5", bus.fetch_valid, bus.fetch_x);
    end
    reset = 1'b0;
    #1;
    snap = {bus.fetch_x, bus.fetch_y, bus.fetch_valid, bus.pix_valid, bus.pix_bank,
            bus.bank_full, bus.busy, bus.frame_done, bus.underrun, bus.stall_cycles};
    checks++;
    if (snap !== '0 || bus.rd_bank !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got outputs=%h rd_bank=%0b, want 0 and 1", snap, bus.rd_bank);
    end
    tick();
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.fetch_valid || bus.busy) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL no_resume: got %0d active cycles after reset release, want 0", seen);
    end
  endtask

  task automatic test_underrun();
    tick();
    bus.chunk_done = 1'b1;
    tick();
    bus.chunk_done = 1'b0;
    checks++;
    if (bus.underrun !== 1'b1 || bus.rd_bank !== 1'b1 || bus.bank_full !== 2'b00) begin
      errors++;
      $display("FAIL underrun_set: got underrun=%0b rd_bank=%0b full=%b, want 1 1 00",
               bus.underrun, bus.rd_bank, bus.bank_full);
    end
    repeat (3) tick();
    checks++;
    if (bus.underrun !== 1'b1) begin
      errors++;
      $display("FAIL underrun_sticky: got %0b, want 1", bus.underrun);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.underrun !== 1'b0) begin
      errors++;
      $display("FAIL underrun_clear: got %0b, want 0", bus.underrun);
    end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_fill_wait();
    int          nvalid;
    logic        gap;
    logic        bad;
    logic [15:0] exp_stall;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    nvalid = 0;
    gap    = 1'b0;
    bad    = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (bus.fetch_valid) begin
        nvalid++;
        if (gap) bad = 1'b1;
      end else begin
        gap = 1'b1;
      end
      tick();
    end
    checks++;
    if (nvalid != 32 || bad) begin
      errors++;
      $display("FAIL fill_burst: got %0d issues (gap=%0b), want 32 contiguous", nvalid, bad);
    end
    checks++;
    if (bus.fetch_valid !== 1'b0 || bus.busy !== 1'b1 || bus.fetch_x !== 10'd32 ||
        bus.fetch_y !== 10'd0) begin
      errors++;
      $display("FAIL wait_hold: got valid=%0b busy=%0b (%0d,%0d), want 0 1 (32,0)",
               bus.fetch_valid, bus.busy, bus.fetch_x, bus.fetch_y);
    end
    checks++;
    if (bus.bank_full !== 2'b11 || bus.rd_bank !== 1'b1) begin
      errors++;
      $display("FAIL both_full: got full=%b rd_bank=%0b, want 11 1", bus.bank_full, bus.rd_bank);
    end
`ifdef MERGE_FILL_STATS_EN
    exp_stall = 16'd8;
`else
    exp_stall = 16'd0;
`endif
    checks++;
    if (bus.stall_cycles !== exp_stall) begin
      errors++;
      $display("FAIL stall_count: got %0d, want %0d", bus.stall_cycles, exp_stall);
    end
  endtask

  task automatic test_release();
    bus.chunk_done = 1'b1;
    tick();
    bus.chunk_done = 1'b0;
    checks++;
    if (bus.bank_full !== 2'b01 || bus.rd_bank !== 1'b0 || bus.fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL release: got full=%b rd_bank=%0b valid=%0b, want 01 0 0",
               bus.bank_full, bus.rd_bank, bus.fetch_valid);
    end
    tick();
    checks++;
    if (bus.fetch_valid !== 1'b1 || bus.fetch_x !== 10'd32 || bus.fetch_y !== 10'd0) begin
      errors++;
      $display("FAIL resume: got valid=%0b (%0d,%0d), want 1 (32,0)",
               bus.fetch_valid, bus.fetch_x, bus.fetch_y);
    end
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    checks++;
    if (bus.fetch_x !== 10'd33 || bus.fetch_y !== 10'd0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL start_ignored: got (%0d,%0d) busy=%0b, want (33,0) 1",
               bus.fetch_x, bus.fetch_y, bus.busy);
    end
  endtask

  task automatic test_full_frame();
    int pulses;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    pulses = 0;
    for (int c = 1; c <= N_CHUNKS * CH + 40; c++) begin
      if (c >= 20 && (c - 20) % CH == 0 && pulses < N_CHUNKS) begin
        bus.chunk_done = 1'b1;
        pulses++;
      end else begin
        bus.chunk_done = 1'b0;
      end
      tick();
    end
    bus.chunk_done = 1'b0;
    checks++;
    if (pix_cnt != H * V || done_cnt != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL frame_count: got pix=%0d done=%0d pending=%0d, want %0d 1 0",
               pix_cnt, done_cnt, exp_q.size(), H * V);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.bank_full !== 2'b00 || bus.underrun !== 1'b0 ||
        bus.rd_bank !== 1'b1 || bus.stall_cycles !== 16'd0) begin
      errors++;
      $display("FAIL frame_end_state: got busy=%0b full=%b under=%0b rd=%0b stall=%0d, want 0 00 0 1 0",
               bus.busy, bus.bank_full, bus.underrun, bus.rd_bank, bus.stall_cycles);
    end
  endtask

  task automatic test_same_bank_collision();
    int first_pix;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    bus3.frame_start = 1'b1;
    tick();
    bus3.frame_start = 1'b0;
    first_pix = 0;
    for (int c = 1; c <= 18; c++) begin
      if (bus3.pix_valid && first_pix == 0) first_pix = c;
      tick();
    end
    checks++;
    if (first_pix != 1 + LAT3) begin
      errors++;
      $display("FAIL lat3_lag: got first pix_valid in cycle %0d, want %0d", first_pix, 1 + LAT3);
    end
    checks++;
    if (bus3.bank_full !== 2'b00 || bus3.pix_valid !== 1'b1) begin
      errors++;
      $display("FAIL lat3_pre: got full=%b pix_valid=%0b, want 00 1", bus3.bank_full, bus3.pix_valid);
    end
    bus3.chunk_done = 1'b1;
    tick();
    bus3.chunk_done = 1'b0;
    checks++;
    if (bus3.bank_full !== 2'b10 || bus3.underrun !== 1'b1 || bus3.rd_bank !== 1'b1) begin
      errors++;
      $display("FAIL set_wins: got full=%b under=%0b rd=%0b, want 10 1 1",
               bus3.bank_full, bus3.underrun, bus3.rd_bank);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_reset_mid_fill();
    test_underrun();
    test_fill_wait();
    test_release();
    test_full_frame();
    test_same_bank_collision();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
